ajuste_reloj_ctrl: RTL and testbench

Time-setting controller for the digital clock. It generates the 1 Hz seconds tick and sequences the hours/minutes/seconds counters through RUN, SET_HOR and SET_MIN modes from two debounced push-buttons. In set modes it issues single-cycle increment pulses, with press-and-hold auto-repeat and an inactivity timeout. It sits between the button debouncers and the contadorSegundos/contadorMinutos/contadorHoras counters.

---
 rtl/reloj_pkg.sv | 26 ++
 rtl/ajuste_reloj_ctrl_if.sv | 30 +++
 rtl/divisor_tick.sv | 49 ++++
 rtl/ajuste_reloj_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ajuste_reloj_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reloj_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reloj_pkg
// Description : Shared definitions for the digital clock: mode encodings,
//               the default seconds divisor and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package reloj_pkg;

  // Operating modes seen on the modo output
  typedef enum logic [1:0] {
    MODO_RUN = 2'd0,
    MODO_HOR = 2'd1,
    MODO_MIN = 2'd2
  } modo_e;

  // Clock cycles per second, shared with the time counters
  localparam int TICK_DIV_DEF = 50_000_000;

  // Width needed for a counter running 0..n-1 (never narrower than 1 bit)
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ajuste_reloj_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ajuste_reloj_ctrl_if
// Description : Button inputs and counter-control outputs of the
//               time-setting controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ajuste_reloj_ctrl_if;
  logic       btnModo;
  logic       btnInc;
  logic       tickSeg;
  logic       incHor;
  logic       incMin;
  logic       clrSeg;
  logic [1:0] modo;
  logic       parpadeo;

  // Environment side: drives the buttons, consumes the pulses
  modport master (
    output btnModo, btnInc,
    input  tickSeg, incHor, incMin, clrSeg, modo, parpadeo
  );

  // Controller side
  modport slave (
    input  btnModo, btnInc,
    output tickSeg, incHor, incMin, clrSeg, modo, parpadeo
  );
endinterface
`default_nettype wire

// File: rtl/divisor_tick.sv
`default_nettype none
// ============================================================================
// Module      : divisor_tick
// Description : Modulus-N free-running prescaler with synchronous clear.
//               tick_o is high in the cycle the count equals N-1.
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_tick
  import reloj_pkg::*;
#(
  parameter int N = TICK_DIV_DEF,
  parameter int W = cnt_w(N)
) (
  input  wire logic         clock,
  input  wire logic         resetN,
  input  wire logic         clr_i,
  output logic              tick_o,
  output logic [W-1:0]      cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = (cnt_q == W'(N - 1));
  assign cnt_o  = cnt_q;

  // Next count: clear wins, otherwise wrap at N-1
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ajuste_reloj_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ajuste_reloj_ctrl
// Description : Time-setting controller. Generates the seconds enable,
//               steps RUN -> SET_HOR -> SET_MIN -> RUN from the mode button,
//               issues increment pulses with hold auto-repeat, and falls back
//               to RUN after an inactivity timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ajuste_reloj_ctrl
  import reloj_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int HOLD_DLY   = 50_000_000,
  parameter int REPEAT_DIV = 25_000_000,
  parameter int TIMEOUT_S  = 10
) (
  input  wire logic           clock,
  input  wire logic           resetN,
  ajuste_reloj_ctrl_if.slave  ctrl
);

  localparam int PW = cnt_w(TICK_DIV);
  localparam int HW = cnt_w(HOLD_DLY);
  localparam int RW = cnt_w(REPEAT_DIV);
  localparam int TW = cnt_w(TIMEOUT_S);

  logic [PW-1:0] w_cnt;
  logic          w_tick;
  logic          w_exit;

  modo_e         modo_q, modo_d;
  logic          modo_prev_q, inc_prev_q;
  logic [HW-1:0] hold_q, hold_d;
  logic          rep_act_q, rep_act_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [TW-1:0] to_q, to_d;
  logic          tick_seg_q, tick_seg_d;
  logic          inc_hor_q, inc_hor_d;
  logic          inc_min_q, inc_min_d;
  logic          clr_seg_q, clr_seg_d;
  logic          parp_q, parp_d;

  logic          w_set;
  logic          w_modo_edge;
  logic          w_inc_edge;
  logic          w_rep_pulse;
  logic          w_pulse;
  logic          w_timeout;

  // History registers reset to 1 so a button held through reset gives no edge
  assign w_modo_edge = ctrl.btnModo & ~modo_prev_q;
  assign w_inc_edge  = ctrl.btnInc  & ~inc_prev_q;
  // Repeat pulse only while the button is still down
  assign w_rep_pulse = ctrl.btnInc & rep_act_q & (rep_q == '0);
  assign w_pulse     = w_inc_edge | w_rep_pulse;
  assign w_set       = (modo_q == MODO_HOR) || (modo_q == MODO_MIN);
  assign w_timeout   = w_set && w_tick && (to_q == TW'(TIMEOUT_S - 1));

  // Seconds prescaler, restarted on every exit to RUN
  divisor_tick #(
    .N (TICK_DIV),
    .W (PW)
  ) u_divisor (
    .clock  (clock),
    .resetN (resetN),
    .clr_i  (w_exit),
    .tick_o (w_tick),
    .cnt_o  (w_cnt)
  );

  // Mode sequencing, hold/repeat and timeout next-state, output pulse decode
  always_comb begin
    modo_d     = modo_q;
    hold_d     = hold_q;
    rep_act_d  = rep_act_q;
    rep_d      = rep_q;
    to_d       = to_q;
    inc_hor_d  = 1'b0;
    inc_min_d  = 1'b0;
    clr_seg_d  = 1'b0;
    w_exit     = 1'b0;

    case (modo_q)
      MODO_RUN: begin
        hold_d    = '0;
        rep_act_d = 1'b0;
        rep_d     = '0;
        to_d      = '0;
        if (w_modo_edge) begin
          modo_d = MODO_HOR;
        end
      end

      MODO_HOR, MODO_MIN: begin
        if (w_modo_edge || w_timeout) begin
          // Mode change or timeout: any increment this cycle is dropped
          hold_d    = '0;
          rep_act_d = 1'b0;
          rep_d     = '0;
          to_d      = '0;
          if (w_timeout || (modo_q == MODO_MIN)) begin
            modo_d    = MODO_RUN;
            clr_seg_d = 1'b1;
            w_exit    = 1'b1;
          end else begin
            modo_d = MODO_MIN;
          end
        end else begin
          if (!ctrl.btnInc) begin
            hold_d    = '0;
            rep_act_d = 1'b0;
            rep_d     = '0;
          end else if (w_inc_edge) begin
            hold_d    = HW'(1);
            rep_act_d = 1'b0;
            rep_d     = '0;
          end else if (rep_act_q) begin
            rep_d = (rep_q == RW'(REPEAT_DIV - 1)) ? '0 : rep_q + 1'b1;
          end else if (hold_q == HW'(HOLD_DLY - 1)) begin
            // Next cycle is hold count HOLD_DLY: first repeat pulse
            rep_act_d = 1'b1;
            rep_d     = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end

          if (w_pulse) begin
            inc_hor_d = (modo_q == MODO_HOR);
            inc_min_d = (modo_q == MODO_MIN);
            to_d      = '0;
          end else if (w_tick) begin
            to_d = to_q + 1'b1;
          end
        end
      end

      default: begin
        modo_d    = MODO_RUN;
        hold_d    = '0;
        rep_act_d = 1'b0;
        rep_d     = '0;
        to_d      = '0;
      end
    endcase

    tick_seg_d = w_tick && (modo_q == MODO_RUN);
    parp_d     = (modo_d != MODO_RUN) && (w_cnt < PW'(TICK_DIV / 2));
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      modo_q      <= MODO_RUN;
      modo_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
      hold_q      <= '0;
      rep_act_q   <= 1'b0;
      rep_q       <= '0;
      to_q        <= '0;
      tick_seg_q  <= 1'b0;
      inc_hor_q   <= 1'b0;
      inc_min_q   <= 1'b0;
      clr_seg_q   <= 1'b0;
      parp_q      <= 1'b0;
    end else begin
      modo_q      <= modo_d;
      modo_prev_q <= ctrl.btnModo;
      inc_prev_q  <= ctrl.btnInc;
      hold_q      <= hold_d;
      rep_act_q   <= rep_act_d;
      rep_q       <= rep_d;
      to_q        <= to_d;
      tick_seg_q  <= tick_seg_d;
      inc_hor_q   <= inc_hor_d;
      inc_min_q   <= inc_min_d;
      clr_seg_q   <= clr_seg_d;
      parp_q      <= parp_d;
    end
  end

  assign ctrl.tickSeg  = tick_seg_q;
  assign ctrl.incHor   = inc_hor_q;
  assign ctrl.incMin   = inc_min_q;
  assign ctrl.clrSeg   = clr_seg_q;
  assign ctrl.modo     = modo_q;
  assign ctrl.parpadeo = parp_q;

endmodule
`default_nettype wire

// File: tb/tb_ajuste_reloj_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ajuste_reloj_ctrl
// Description : Directed self-checking bench for ajuste_reloj_ctrl with
//               TICK_DIV=10, HOLD_DLY=20, REPEAT_DIV=5, TIMEOUT_S=3.
//               Cycle numbers below count clock edges since reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ajuste_reloj_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  ajuste_reloj_ctrl_if bus ();

  ajuste_reloj_ctrl #(
    .TICK_DIV   (10),
    .HOLD_DLY   (20),
    .REPEAT_DIV (5),
    .TIMEOUT_S  (3)
  ) dut (
    .clock  (clk),
    .resetN (rst_n),
    .ctrl   (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.tickSeg, bus.incHor, bus.incMin, bus.clrSeg, bus.parpadeo});
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_tick, first_tick, n_hor, hor_pos, n_min, n_clr, n_other, pos_exit, pos_clr;
    int pmin[8];
    logic [9:0] pat;

    bus.btnModo = 1'b0;
    bus.btnInc  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_modo", 32'(bus.modo), 0);
    chk("reset_outs", outs(), 0);

    // ---- RUN: ticks at cycles 10 and 20 -----------------------------------
    rst_n = 1'b1;
    cyc = 0;
    n_tick = 0; first_tick = -1; n_other = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.tickSeg) begin
        n_tick++;
        if (first_tick < 0) first_tick = cyc;
      end
      if (bus.incHor || bus.incMin || bus.clrSeg) n_other++;
    end
    chk("run_first_tick", 32'(first_tick), 10);
    chk("run_tick_count", 32'(n_tick), 2);
    chk("run_no_pulses", 32'(n_other), 0);
    chk("run_modo", 32'(bus.modo), 0);

    // ---- SET_HOR: single increment, blink pattern, no ticks ----------------
    bus.btnModo = 1'b1;
    step();                                   // 21
    chk("hor_enter", 32'(bus.modo), 1);
    bus.btnModo = 1'b0;
    bus.btnInc  = 1'b1;
    pat = '0;
    pat[0] = bus.parpadeo;
    n_tick = 0; n_hor = 0; hor_pos = -1; n_other = 0;
    for (int i = 1; i < 10; i++) begin
      step();                                 // 22..30
      if (i == 1) bus.btnInc = 1'b0;
      pat[i] = bus.parpadeo;
      if (bus.tickSeg) n_tick++;
      if (bus.incHor) begin
        n_hor++;
        hor_pos = cyc;
      end
      if (bus.incMin || bus.clrSeg) n_other++;
    end
    chk("hor_inc_count", 32'(n_hor), 1);
    chk("hor_inc_pos", 32'(hor_pos), 22);
    chk("hor_blink", 32'(pat), 32'h01F);
    chk("hor_no_tick", 32'(n_tick), 0);
    chk("hor_no_other", 32'(n_other), 0);

    // ---- SET_MIN: hold 38 cycles -> pulses at 32,52,57,62,67 ---------------
    bus.btnModo = 1'b1;
    step();                                   // 31
    chk("min_enter", 32'(bus.modo), 2);
    bus.btnModo = 1'b0;
    bus.btnInc  = 1'b1;
    n_min = 0; n_hor = 0; n_other = 0;
    for (int i = 0; i < 8; i++) pmin[i] = -1;
    for (int i = 0; i < 38; i++) begin
      step();                                 // 32..69
      if (bus.incMin) begin
        if (n_min < 8) pmin[n_min] = cyc;
        n_min++;
      end
      if (bus.incHor) n_hor++;
      if (bus.clrSeg) n_other++;
    end
    bus.btnInc = 1'b0;
    chk("rep_count", 32'(n_min), 5);
    chk("rep_pos0", 32'(pmin[0]), 32);
    chk("rep_pos1", 32'(pmin[1]), 52);
    chk("rep_pos2", 32'(pmin[2]), 57);
    chk("rep_pos3", 32'(pmin[3]), 62);
    chk("rep_pos4", 32'(pmin[4]), 67);
    chk("rep_no_hor", 32'(n_hor), 0);
    chk("rep_no_clr", 32'(n_other), 0);
    chk("rep_modo", 32'(bus.modo), 2);

    // ---- Exit to RUN by button: one clrSeg, next tick 10 cycles later ------
    repeat (3) step();                        // 70..72
    bus.btnModo = 1'b1;
    step();                                   // 73
    chk("exit_modo", 32'(bus.modo), 0);
    chk("exit_clr", 32'(bus.clrSeg), 1);
    bus.btnModo = 1'b0;
    n_tick = 0; first_tick = -1; n_clr = 0;
    for (int i = 0; i < 10; i++) begin
      step();                                 // 74..83
      if (bus.tickSeg) begin
        n_tick++;
        if (first_tick < 0) first_tick = cyc;
      end
      if (bus.clrSeg) n_clr++;
    end
    chk("exit_first_tick", 32'(first_tick), 83);
    chk("exit_tick_count", 32'(n_tick), 1);
    chk("exit_single_clr", 32'(n_clr), 0);

    // ---- Inactivity timeout in SET_HOR: ticks at 93,103, exit at 113 -------
    bus.btnModo = 1'b1;
    step();                                   // 84
    chk("to_enter", 32'(bus.modo), 1);
    bus.btnModo = 1'b0;
    pos_exit = -1; pos_clr = -1; n_clr = 0;
    for (int i = 0; i < 31; i++) begin
      step();                                 // 85..115
      if (bus.modo == 2'd0 && pos_exit < 0) pos_exit = cyc;
      if (bus.clrSeg) begin
        n_clr++;
        pos_clr = cyc;
      end
    end
    chk("to_exit_pos", 32'(pos_exit), 113);
    chk("to_clr_count", 32'(n_clr), 1);
    chk("to_clr_pos", 32'(pos_clr), 113);

    // ---- Mode edge coincident with timeout (edge 143) ----------------------
    bus.btnModo = 1'b1;
    step();                                   // 116
    chk("co_enter", 32'(bus.modo), 1);
    bus.btnModo = 1'b0;
    n_clr = 0;
    for (int i = 0; i < 26; i++) begin
      step();                                 // 117..142
      if (bus.clrSeg) n_clr++;
    end
    chk("co_pre_modo", 32'(bus.modo), 1);
    chk("co_pre_clr", 32'(n_clr), 0);
    bus.btnModo = 1'b1;
    step();                                   // 143
    chk("co_modo", 32'(bus.modo), 0);
    chk("co_clr", 32'(bus.clrSeg), 1);
    step();                                   // 144
    chk("co_modo_after", 32'(bus.modo), 0);
    chk("co_clr_after", 32'(bus.clrSeg), 0);
    bus.btnModo = 1'b0;
    step();                                   // 145
    step();                                   // 146

    // ---- Async reset during a hold in SET_MIN ------------------------------
    bus.btnModo = 1'b1;
    step();                                   // 147
    bus.btnModo = 1'b0;
    step();                                   // 148
    bus.btnModo = 1'b1;
    step();                                   // 149
    chk("ar_min", 32'(bus.modo), 2);
    bus.btnModo = 1'b0;
    bus.btnInc  = 1'b1;
    step();                                   // 150
    chk("ar_inc", 32'(bus.incMin), 1);
    n_min = 0;
    for (int i = 0; i < 15; i++) begin
      step();                                 // 151..165
      if (bus.incMin) n_min++;
    end
    chk("ar_no_early_rep", 32'(n_min), 0);
    chk("ar_blink_on", 32'(bus.parpadeo), 1);
    bus.btnModo = 1'b1;                       // both buttons held through reset
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async_modo", 32'(bus.modo), 0);
    chk("ar_async_outs", outs(), 0);
    repeat (3) step();
    rst_n = 1'b1;
    cyc = 0;
    n_other = 0; n_tick = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.modo != 2'd0) n_tick++;
      if (bus.incHor || bus.incMin || bus.clrSeg) n_other++;
    end
    chk("post_no_mode_edge", 32'(n_tick), 0);
    chk("post_no_pulses", 32'(n_other), 0);
    bus.btnModo = 1'b0;
    step();
    bus.btnModo = 1'b1;
    step();
    chk("post_hor", 32'(bus.modo), 1);
    bus.btnModo = 1'b0;
    n_hor = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.incHor) n_hor++;
    end
    chk("post_no_inc_edge", 32'(n_hor), 0);
    bus.btnInc = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
